// File: rtl/load_store_unit.sv
// RV32I load/store unit: computes the effective address, runs one req/ack
// transaction on the data-memory port and produces register write-back.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] sdata,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [4:0]    rd_q;
  logic          store_q;

  logic [31:0] addr_c;
  logic        legal_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign addr_c = base + imm;

  always_comb begin
    legal_c = 1'b0;
    case (funct3)
      3'b000:  legal_c = 1'b1;
      3'b001:  legal_c = !addr_c[0];
      3'b010:  legal_c = (addr_c[1:0] == 2'b00);
      3'b100:  legal_c = !is_store;
      3'b101:  legal_c = !is_store && !addr_c[0];
      default: legal_c = 1'b0;
    endcase
  end

  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb_c = 4'b0001 << addr_c[1:0];
          wdata_c = {4{sdata[7:0]}};
        end
        2'b01: begin
          wstrb_c = 4'b0011 << addr_c[1:0];
          wdata_c = {2{sdata[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = sdata;
        end
      endcase
    end
  end

  // Byte/half lanes are selected by the latched low address bits.
  assign shifted = dmem_rdata >> {lo_q, 3'b000};

  always_comb begin
    load_val = dmem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      rd_q       <= 5'd0;
      store_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wstrb <= 4'b0000;
      dmem_wdata <= 32'h0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wb_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            f3_q    <= funct3;
            lo_q    <= addr_c[1:0];
            rd_q    <= rd;
            store_q <= is_store;
            if (legal_c) begin
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_addr  <= {addr_c[31:2], 2'b00};
              dmem_wstrb <= wstrb_c;
              dmem_wdata <= wdata_c;
              cnt        <= CW'(TIMEOUT - 1);
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            done     <= 1'b1;
            if (!store_q) begin
              wb_rd   <= rd_q;
              wb_data <= load_val;
              wb_we   <= (rd_q != 5'd0);
            end
          end else if (cnt == '0) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected memory
// requests and completions; a memory responder and a completion monitor check them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base, imm, sdata;
  logic [4:0]  rd;
  logic        busy, done, err, dmem_req;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .base(base), .imm(imm), .sdata(sdata), .rd(rd),
    .busy(busy), .done(done), .err(err), .dmem_req(dmem_req),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } done_t;

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_t;

  done_t exp_q[$];
  mem_t  mem_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_rdata;
  int          mem_delay;
  bit          mem_withhold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Memory responder: checks the request once, then acks after mem_delay cycles.
  initial begin
    bit   first;
    int   cnt;
    mem_t m;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    first      = 1'b1;
    cnt        = 0;
    forever begin
      @(negedge clk);
      if (dmem_req && !reset) begin
        if (first) begin
          first = 1'b0;
          cnt   = 0;
          checks++;
          if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: got dmem_req=1 addr=%h, expected no request", dmem_addr);
          end else begin
            m = mem_q.pop_front();
            chk("dmem_addr", dmem_addr, m.addr);
            chk("dmem_wstrb", {28'h0, dmem_wstrb}, {28'h0, m.wstrb});
            if (m.st) chk("dmem_wdata", dmem_wdata, m.wdata);
          end
        end else begin
          cnt++;
        end
        if (!mem_withhold && cnt == mem_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = mem_rdata;
        end else begin
          dmem_ack = 1'b0;
        end
      end else begin
        first    = 1'b1;
        dmem_ack = 1'b0;
      end
    end
  end

  // Completion monitor.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wb_we) chk("wb_we_with_done", {31'h0, done}, 32'h1);
        if (done) begin
          chk("busy_at_done", {31'h0, busy}, 32'h1);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no completion");
          end else begin
            e = exp_q.pop_front();
            chk("err", {31'h0, err}, {31'h0, e.err});
            chk("wb_we", {31'h0, wb_we}, {31'h0, e.we});
            if (e.we) begin
              chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
              chk("wb_data", wb_data, e.data);
            end
          end
        end
      end
    end
  end

  task automatic issue(
    input logic st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] im,
    input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdat,
    input int dly, input bit hold, input bit poke, input int exp_lat,
    input logic e_err, input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_data,
    input bit has_mem, input logic [31:0] m_addr, input logic [3:0] m_wstrb,
    input logic [31:0] m_wdata);
    done_t d;
    mem_t  m;
    int    k;
    bit    seen;
    @(negedge clk);
    is_store = st; funct3 = f3; base = b; imm = im; sdata = sd; rd = r;
    mem_rdata = rdat; mem_delay = dly; mem_withhold = hold;
    d.err = e_err; d.we = e_we; d.rd = e_rd; d.data = e_data;
    exp_q.push_back(d);
    if (has_mem) begin
      m.st = st; m.addr = m_addr; m.wstrb = m_wstrb; m.wdata = m_wdata;
      mem_q.push_back(m);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy_after_accept", {31'h0, busy}, 32'h1);
      if (poke) begin
        if (k == 2) start = 1'b1;
        if (k == 3) start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("latency", k, exp_lat);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    base = 32'h0; imm = 32'h0; sdata = 32'h0; rd = 5'd0;
    mem_rdata = 32'h0; mem_delay = 0; mem_withhold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    reset = 1'b0;

    // LW / LB / LBU / SH
    issue(0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 0, 2,
          0, 1, 5'd5, 32'hDEADBEEF, 1, 32'h104, 4'b0000, 32'h0);
    issue(0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd6, 32'h80AABBCC, 0, 0, 0, 2,
          0, 1, 5'd6, 32'hFFFFFF80, 1, 32'h100, 4'b0000, 32'h0);
    issue(0, 3'b100, 32'h100, 32'h3, 32'h0, 5'd7, 32'h80AABBCC, 1, 0, 0, 3,
          0, 1, 5'd7, 32'h00000080, 1, 32'h100, 4'b0000, 32'h0);
    issue(1, 3'b001, 32'h200, 32'h2, 32'h1234ABCD, 5'd4, 32'h0, 0, 0, 0, 2,
          0, 0, 5'd0, 32'h0, 1, 32'h200, 4'b1100, 32'hABCDABCD);
    // Misaligned LW: error one cycle after accept, no request
    issue(0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd5, 32'h0, 0, 0, 0, 1,
          1, 0, 5'd0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    // LW to x0: completes, no write-back
    issue(0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd0, 32'h55, 0, 0, 0, 2,
          0, 0, 5'd0, 32'h0, 1, 32'h300, 4'b0000, 32'h0);
    // LH upper half, LHU with 2-cycle ack delay
    issue(0, 3'b001, 32'h0, 32'h12, 32'h0, 5'd8, 32'h80017FFF, 0, 0, 0, 2,
          0, 1, 5'd8, 32'hFFFF8001, 1, 32'h10, 4'b0000, 32'h0);
    issue(0, 3'b101, 32'h10, 32'h0, 32'h0, 5'd9, 32'h00009234, 2, 0, 0, 4,
          0, 1, 5'd9, 32'h00009234, 1, 32'h10, 4'b0000, 32'h0);
    // SB with negative offset into lane 3, SW
    issue(1, 3'b000, 32'h400, 32'hFFFFFFFF, 32'h123456EF, 5'd0, 32'h0, 0, 0, 0, 2,
          0, 0, 5'd0, 32'h0, 1, 32'h3FC, 4'b1000, 32'hEFEFEFEF);
    issue(1, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 5'd0, 32'h0, 1, 0, 0, 3,
          0, 0, 5'd0, 32'h0, 1, 32'h500, 4'b1111, 32'hCAFEF00D);
    // Illegal encodings and misaligned SH
    issue(0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd3, 32'h0, 0, 0, 0, 1,
          1, 0, 5'd0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    issue(1, 3'b100, 32'h100, 32'h0, 32'h11, 5'd0, 32'h0, 0, 0, 0, 1,
          1, 0, 5'd0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    issue(1, 3'b001, 32'h201, 32'h0, 32'h11, 5'd0, 32'h0, 0, 0, 0, 1,
          1, 0, 5'd0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    // Timeout after 4 ACCESS cycles; a start pulse mid-access must be ignored
    issue(0, 3'b010, 32'h700, 32'h0, 32'h0, 5'd4, 32'h0, 0, 1, 1, 5,
          1, 0, 5'd0, 32'h0, 1, 32'h700, 4'b0000, 32'h0);

    // Reset in the middle of ACCESS
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; base = 32'h600; imm = 32'h0; rd = 5'd3;
    mem_withhold = 1'b1;
    begin
      mem_t m;
      m.st = 1'b0; m.addr = 32'h600; m.wstrb = 4'b0000; m.wdata = 32'h0;
      mem_q.push_back(m);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    chk("req_before_reset", {31'h0, dmem_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("reset_req", {31'h0, dmem_req}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_wb_we", {31'h0, wb_we}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_withhold = 1'b0;
    repeat (3) @(negedge clk);

    // Recovery after reset
    issue(0, 3'b010, 32'h800, 32'h8, 32'h0, 5'd10, 32'h13579BDF, 0, 0, 0, 2,
          0, 1, 5'd10, 32'h13579BDF, 1, 32'h808, 4'b0000, 32'h0);

    repeat (4) @(negedge clk);
    chk("pending_done", exp_q.size(), 0);
    chk("pending_req", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no end of stimulus, expected finish before 50000");
    $fatal(1);
  end

endmodule
